// File: rtl/clk_div_monitor.sv
// Monitors a divided clock sampled as data: synchronizes it, emits edge pulses,
// measures period / high time, and tracks lock plus sticky error flags.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 5,
  parameter int EXP_HIGH    = 3,
  parameter int TOL         = 0,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div_in,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err_period,
  output logic             err_timeout
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_W   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   EXP_P_W = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_H_W = (CNT_W+1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [GW-1:0]    LOCK_W  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;
  logic [CNT_W-1:0]       per_cnt, hi_cnt, hi_cap;
  logic [GW-1:0]          good_cnt, good_nxt;
  logic                   meas, good, timeout;
  logic                   err_p_set, err_t_set;

  function automatic logic [CNT_W:0] absdiff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Measurement is judged on the values being published this cycle.
  assign good = (absdiff({1'b0, per_cnt}, EXP_P_W) <= TOL_W) &&
                (absdiff({1'b0, hi_cap},  EXP_H_W) <= TOL_W);
  assign meas    = rise && (state != IDLE);
  assign timeout = !rise && (state != IDLE) && (per_cnt >= TMO_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_p_set = 1'b0;
    err_t_set = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ACQ;
          good_nxt  = '0;
        end
      end
      ACQ: begin
        if (meas) begin
          if (good) begin
            good_nxt = good_cnt + 1'b1;
            if (good_nxt == LOCK_W) state_nxt = LOCKED;
          end else begin
            good_nxt  = '0;
            err_p_set = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          good_nxt  = '0;
          err_t_set = 1'b1;
        end
      end
      LOCKED: begin
        if (meas) begin
          if (!good) begin
            state_nxt = ACQ;
            good_nxt  = '0;
            err_p_set = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          good_nxt  = '0;
          err_t_set = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync        <= '0;
      s_d         <= 1'b0;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      hi_cap      <= '0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      meas_valid  <= 1'b0;
      period      <= '0;
      high_time   <= '0;
      locked      <= 1'b0;
      err_period  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_div_in};
      s_d  <= s;

      if (rise)                    per_cnt <= CNT_ONE;
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;

      if (rise)                         hi_cnt <= CNT_ONE;
      else if (s && hi_cnt != CNT_MAX)  hi_cnt <= hi_cnt + 1'b1;

      // hi_cap stays 0 through a period that never falls.
      if (rise)      hi_cap <= '0;
      else if (fall) hi_cap <= hi_cnt;

      rise_pulse <= rise;
      fall_pulse <= fall;
      meas_valid <= meas;
      if (meas) begin
        period    <= per_cnt;
        high_time <= hi_cap;
      end
      locked      <= (state_nxt == LOCKED);
      err_period  <= err_p_set | (err_period  & ~err_clr);
      err_timeout <= err_t_set | (err_timeout & ~err_clr);
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed scenarios plus random waveforms, every cycle
// compared against an event-level model (edge times, interval arithmetic).
module tb_clk_div_monitor;
  localparam int SYNC   = 2;
  localparam int CW     = 8;
  localparam int EXP_P  = 5;
  localparam int EXP_H  = 3;
  localparam int TOL    = 0;
  localparam int LOCKN  = 4;
  localparam int TMO    = 16;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  logic          clk = 1'b0, rst_n = 1'b0, clk_div_in = 1'b0, err_clr = 1'b0;
  logic          rise_pulse, fall_pulse, meas_valid, locked, err_period, err_timeout;
  logic [CW-1:0] period, high_time;

  clk_div_monitor #(
    .SYNC_STAGES(SYNC), .CNT_W(CW), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H),
    .TOL(TOL), .LOCK_CNT(LOCKN), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .err_clr(err_clr),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .meas_valid(meas_valid),
    .period(period), .high_time(high_time), .locked(locked),
    .err_period(err_period), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks sampled levels, edge times and lock streak.
  bit hist [0:SYNC];
  int edge_n = 0, last_rise = 0, last_fall = 0, streak = 0, mode = M_IDLE;
  bit fall_seen = 0;
  bit e_rise = 0, e_fall = 0, e_meas = 0, e_lock = 0, e_errp = 0, e_errt = 0;
  int e_period = 0, e_high = 0;
  int meas_seen = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_step(input bit lv, input bit clr, input bit rn);
    bit a, b, sp, st;
    int per, hi;
    edge_n++;
    if (!rn) begin
      for (int k = 0; k <= SYNC; k++) hist[k] = 0;
      mode = M_IDLE; streak = 0; fall_seen = 0;
      e_rise = 0; e_fall = 0; e_meas = 0; e_lock = 0; e_errp = 0; e_errt = 0;
      e_period = 0; e_high = 0;
      return;
    end
    // The edge detector acts on the level sampled SYNC edges ago vs. one before it.
    a = hist[SYNC-1];
    b = hist[SYNC];
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = lv;
    e_rise = a && !b;
    e_fall = !a && b;
    e_meas = 0; sp = 0; st = 0;
    if (e_rise) begin
      if (mode != M_IDLE) begin
        per = edge_n - last_rise;
        hi  = fall_seen ? (last_fall - last_rise) : 0;
        e_meas = 1; e_period = per; e_high = hi;
        if (iabs(per - EXP_P) <= TOL && iabs(hi - EXP_H) <= TOL) begin
          streak++;
          if (streak >= LOCKN) mode = M_LOCK;
        end else begin
          sp = 1; streak = 0; mode = M_ACQ;
        end
      end else begin
        mode = M_ACQ; streak = 0;
      end
      last_rise = edge_n;
      fall_seen = 0;
    end else if (mode != M_IDLE && (edge_n - last_rise) == TMO) begin
      st = 1; mode = M_IDLE; streak = 0;
    end
    if (e_fall) begin
      last_fall = edge_n;
      fall_seen = 1;
    end
    e_errp = sp || (e_errp && !clr);
    e_errt = st || (e_errt && !clr);
    e_lock = (mode == M_LOCK);
  endtask

  task automatic cyc(input bit lv, input bit clr = 1'b0, input bit rn = 1'b1);
    clk_div_in = lv; err_clr = clr; rst_n = rn;
    @(posedge clk);
    model_step(lv, clr, rn);
    #1;
    check("rise_pulse",  32'(rise_pulse),  32'(e_rise));
    check("fall_pulse",  32'(fall_pulse),  32'(e_fall));
    check("meas_valid",  32'(meas_valid),  32'(e_meas));
    check("period",      32'(period),      32'(e_period));
    check("high_time",   32'(high_time),   32'(e_high));
    check("locked",      32'(locked),      32'(e_lock));
    check("err_period",  32'(err_period),  32'(e_errp));
    check("err_timeout", 32'(err_timeout), 32'(e_errt));
    if (meas_valid) meas_seen++;
  endtask

  task automatic wave(input int hi, input int lo, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  initial begin
    int hi, lo;
    // Reset, then idle low input
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    check("rst_outputs", 32'({rise_pulse, fall_pulse, meas_valid, locked, err_period, err_timeout}), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    meas_seen = 0;
    for (int i = 0; i < 40; i++) cyc(1'b0);
    check("idle_no_meas", 32'(meas_seen), 32'd0);

    // Nominal 3 high / 2 low
    meas_seen = 0;
    wave(3, 2, 20);
    check("nom_meas_cnt", 32'(meas_seen), 32'd19);
    check("nom_locked", 32'(locked), 32'd1);
    check("nom_period", 32'(period), 32'd5);
    check("nom_high", 32'(high_time), 32'd3);
    check("nom_errs", 32'({err_period, err_timeout}), 32'd0);

    // One stretched low phase while locked
    wave(3, 3, 1);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("bad_period", 32'(period), 32'd6);
    check("bad_err", 32'(err_period), 32'd1);
    check("bad_unlock", 32'(locked), 32'd0);
    cyc(1'b0); cyc(1'b0);
    wave(3, 2, 5);
    check("relock", 32'(locked), 32'd1);

    // Clear colliding with a bad measurement
    wave(3, 4, 1);
    cyc(1'b1); cyc(1'b1); cyc(1'b1, 1'b1);
    check("clr_collision", 32'(err_period), 32'd1);
    cyc(1'b0, 1'b1);
    check("clr_after", 32'(err_period), 32'd0);
    cyc(1'b0);

    // Timeout while locked
    wave(3, 2, 6);
    check("pre_tmo_lock", 32'(locked), 32'd1);
    for (int i = 0; i < 25; i++) cyc(1'b0);
    check("tmo_flag", 32'(err_timeout), 32'd1);
    check("tmo_unlock", 32'(locked), 32'd0);
    meas_seen = 0;
    wave(3, 2, 1);
    check("tmo_idle_rise", 32'(meas_seen), 32'd0);
    cyc(1'b1, 1'b1);
    check("tmo_clr", 32'({err_period, err_timeout}), 32'd0);
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);

    // Reset mid-lock
    wave(3, 2, 6);
    check("pre_rst_lock", 32'(locked), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    check("mid_rst_outputs", 32'({rise_pulse, fall_pulse, meas_valid, locked, err_period, err_timeout}), 32'd0);
    check("mid_rst_meas", 32'({period, high_time}), 32'd0);
    wave(3, 2, 4);
    check("relock_early", 32'(locked), 32'd0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("relock_after_rst", 32'(locked), 32'd1);
    cyc(1'b0); cyc(1'b0);

    // Random waveforms, clears and resets
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 1) == 0) begin
        hi = 3; lo = 2;
      end else begin
        hi = $urandom_range(1, 6);
        lo = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 22) : $urandom_range(1, 6);
      end
      if ($urandom_range(0, 49) == 0) cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < hi; i++) cyc(1'b1, ($urandom_range(0, 15) == 0));
      for (int i = 0; i < lo; i++) cyc(1'b0, ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
